result_serializer: RTL and testbench

- Downstream of the control unit's SEND_RESULT phase. Streams the N×N result matrix out of result memory as UART bytes.
- Each result element is 16 bits and is sent as two bytes, high byte first.
- Drives the UART transmitter through a tx_start/tx_busy handshake.
- Pulses done when the last byte has left the transmitter.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/result_serializer.sv | 116 +++++++++++
 tb/tb_result_serializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and the serializer state encoding for the matmul result path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package matmul_pkg;

   localparam int ELEM_W = 16;
   localparam int MAX_N  = 8;

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] FETCH   = 4'd1;
   localparam logic [3:0] LATCH   = 4'd2;
   localparam logic [3:0] SEND_HI = 4'd3;
   localparam logic [3:0] HOLD_HI = 4'd4;
   localparam logic [3:0] WAIT_HI = 4'd5;
   localparam logic [3:0] SEND_LO = 4'd6;
   localparam logic [3:0] HOLD_LO = 4'd7;
   localparam logic [3:0] WAIT_LO = 4'd8;
   localparam logic [3:0] FIN     = 4'd9;

endpackage

// File: rtl/result_serializer.sv
// Streams the N x N result matrix from result memory to the UART as bytes, high byte first.
// Latency: 2 fetch cycles then 3 cycles per byte minimum; done pulses one cycle after the last byte drains.
// Backpressure: tx_start is held off while tx_busy is high; the FSM waits on the transmitter with no timeout.
module result_serializer #(
   parameter int ELEM_W = matmul_pkg::ELEM_W,
   parameter int MAX_N  = matmul_pkg::MAX_N,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        matrix_size,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [ELEM_W-1:0] rd_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done
);
   import matmul_pkg::*;

   // Element count needs one extra bit so that MAX_N*MAX_N itself is representable.
   localparam int         TW   = ADDR_W + 1;
   localparam logic [3:0] NMAX = 4'(MAX_N);

   logic [3:0]        r_state;
   logic [3:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [TW-1:0]     r_total;
   logic [ELEM_W-1:0] r_buf;
   logic              r_sel_lo;

   logic [3:0]        w_n;
   logic [TW-1:0]     w_n_ext;
   logic [TW-1:0]     w_total;
   logic              w_last;
   logic              w_in_send;
   logic              w_in_hold;
   logic              w_in_wait;

   assign w_n       = (matrix_size > NMAX) ? NMAX : matrix_size;
   assign w_n_ext   = TW'(w_n);
   assign w_total   = w_n_ext * w_n_ext;
   assign w_last    = ({1'b0, r_idx} == (r_total - TW'(1)));

   // Hi and lo phases share one send/hold/wait path; r_sel_lo picks the byte and the successor state.
   assign w_in_send = (r_state == SEND_HI) || (r_state == SEND_LO);
   assign w_in_hold = (r_state == HOLD_HI) || (r_state == HOLD_LO);
   assign w_in_wait = (r_state == WAIT_HI) || (r_state == WAIT_LO);

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == IDLE) begin
         if (start) w_state_nxt = (w_n == 4'd0) ? FIN : FETCH;
      end else if (r_state == FETCH) begin
         w_state_nxt = LATCH;
      end else if (r_state == LATCH) begin
         w_state_nxt = SEND_HI;
      end else if (w_in_send) begin
         if (!tx_busy) w_state_nxt = r_sel_lo ? HOLD_LO : HOLD_HI;
      end else if (w_in_hold) begin
         // tx_busy is ignored here: it only rises the cycle after tx_start.
         w_state_nxt = r_sel_lo ? WAIT_LO : WAIT_HI;
      end else if (w_in_wait) begin
         if (!tx_busy) begin
            if (!r_sel_lo)   w_state_nxt = SEND_LO;
            else if (w_last) w_state_nxt = FIN;
            else             w_state_nxt = FETCH;
         end
      end else begin
         w_state_nxt = IDLE;
      end
   end

   // State register plus element index, latched size, element buffer and byte select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_total  <= '0;
         r_buf    <= '0;
         r_sel_lo <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && start) begin
            r_total  <= w_total;
            r_idx    <= '0;
            r_sel_lo <= 1'b0;
         end
         if (r_state == LATCH) begin
            r_buf    <= rd_data;
            r_sel_lo <= 1'b0;
         end
         if (w_in_wait && !tx_busy) begin
            if (!r_sel_lo) begin
               r_sel_lo <= 1'b1;
            end else if (!w_last) begin
               r_idx <= r_idx + ADDR_W'(1);
            end
         end
      end
   end

   // Outputs decode from registered state; the buffer only changes in LATCH, after tx_busy has fallen,
   // so tx_data stays stable for the whole byte.
   assign rd_en    = (r_state == FETCH);
   assign rd_addr  = (r_state == FETCH) ? r_idx : '0;
   assign tx_start = w_in_send && !tx_busy;
   assign tx_data  = r_sel_lo ? r_buf[7:0] : r_buf[ELEM_W-1 -: 8];
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == FIN);

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboarded bench for result_serializer with memory and UART transmitter models.
// Latency: n/a.
// Backpressure: transmitter model holds tx_busy high for a per-byte programmable length.
module tb_result_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  matrix_size = 4'd0;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [15:0] rd_data = 16'h0000;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        busy;
   logic        done;

   result_serializer #(.ELEM_W(16), .MAX_N(8), .ADDR_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] mem[64];
   int          tx_cnt = 0;
   int          rd_cnt = 0;
   int          done_cnt = 0;
   int          exp_addr = 0;
   int          last_addr = -1;
   int          model_bcnt = 0;
   int          stretch_idx = -1;
   logic [7:0]  last_byte = 8'h00;
   bit          mon_en = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Result memory: data appears one cycle after rd_en, garbage otherwise.
   initial begin
      logic [5:0] a;
      forever begin
         @(negedge clk);
         if (rd_en) begin
            a = rd_addr;
            @(posedge clk);
            #1 rd_data = mem[a];
            @(posedge clk);
            #1 rd_data = 16'hDEAD;
         end
      end
   end

   // Transmitter: busy rises the cycle after tx_start and stays high for 10 cycles (50 for the stretched byte).
   initial begin
      int len;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            len = (model_bcnt == stretch_idx) ? 50 : 10;
            model_bcnt++;
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Output monitor: byte order, no launch while busy, data stability, fetch addresses.
   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_start) begin
            chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            last_byte = tx_data;
            tx_cnt++;
         end else if (tx_busy) begin
            chk("tx_data_stable", {24'd0, tx_data}, {24'd0, last_byte});
         end
         if (rd_en) begin
            chk("rd_addr", {26'd0, rd_addr}, exp_addr);
            exp_addr++;
            last_addr = int'(rd_addr);
            rd_cnt++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic run_xfer(input logic [3:0] size, input bit restart);
      int  n;
      bit  seen;
      int  done_at;
      n = (size > 4'd8) ? 8 : int'(size);
      exp_q.delete();
      for (int e = 0; e < n * n; e++) begin
         exp_q.push_back(mem[e][15:8]);
         exp_q.push_back(mem[e][7:0]);
      end
      tx_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_addr = 0; last_addr = -1; model_bcnt = 0;
      @(posedge clk);
      #1 start = 1'b1; matrix_size = size;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      done_at = -1;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clk);
         if (restart && i == 30) begin
            chk("busy_mid_xfer", {31'd0, busy}, 32'd1);
            start = 1'b1; matrix_size = 4'd5;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            done_at = i;
            chk("tx_busy_low_at_done", {31'd0, tx_busy}, 32'd0);
         end
      end
      start = 1'b0;
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      if (n == 0) chk("done_latency_n0", done_at, 32'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("done_pulses", done_cnt, 32'd1);
      chk("tx_start_count", tx_cnt, 2 * n * n);
      chk("rd_en_count", rd_cnt, n * n);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      if (n > 0) chk("last_rd_addr", last_addr, n * n - 1);
   endtask

   initial begin
      #1;
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_rd_addr", {26'd0, rd_addr}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // N=2 basic ordering.
      mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
      run_xfer(4'd2, 1'b0);

      // N=0: immediate done, nothing sent or fetched.
      run_xfer(4'd0, 1'b0);

      // N=3 with byte 5 stretched to 50 busy cycles.
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h1111) ^ 16'h0F5A;
      stretch_idx = 5;
      run_xfer(4'd3, 1'b0);
      stretch_idx = -1;

      // matrix_size 9 clamps to 8.
      for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'(8'hFF - 8'(i))};
      run_xfer(4'd9, 1'b0);

      // Second start during an N=2 transfer is ignored.
      mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
      run_xfer(4'd2, 1'b1);

      // Reset asserted in WAIT_LO of element 1.
      exp_q.delete();
      for (int e = 0; e < 4; e++) begin
         exp_q.push_back(mem[e][15:8]);
         exp_q.push_back(mem[e][7:0]);
      end
      tx_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_addr = 0; model_bcnt = 0;
      @(posedge clk);
      #1 start = 1'b1; matrix_size = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 2000 && tx_cnt < 4; i++) begin
         @(negedge clk);
         #1;
      end
      if (tx_cnt < 4) chk("reach_elem1_lo_timeout", tx_cnt, 32'd4);
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("arst_rd_addr", {26'd0, rd_addr}, 32'd0);
      chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      repeat (15) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      tx_cnt = 0;
      mon_en = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("no_tx_after_reset", tx_cnt, 32'd0);
      chk("idle_after_reset", {31'd0, busy}, 32'd0);
      mem[0] = 16'h5A5A;
      run_xfer(4'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
